// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Link between the frame controller, its majority-vote sampler and the word consumer.
interface uart_rx_frame_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned EDGE_W     = 5
);
    logic                  data_samp_en;
    logic [EDGE_W-1:0]     edge_cnt;
    logic                  sampled_bit;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output data_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err,
        input  sampled_bit
    );

    modport slave (
        input  data_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err,
        output sampled_bit
    );
endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Per-bit edge counter and frame bit counter; be strobes on the last clock of each bit.
module uart_rx_edge_bit_cnt #(
    parameter int unsigned EDGE_W = 5,
    parameter int unsigned BIT_W  = 3
) (
    input  logic              clk,
    input  logic              ARSTn,
    input  logic              en,
    input  logic [EDGE_W-1:0] last_edge,
    input  logic              bit_clr,
    input  logic              bit_inc,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              be
);
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;

    always_comb begin
        be         = en && (edge_cnt_q == last_edge);
        edge_cnt_d = edge_cnt_q + EDGE_W'(1);
        if (!en || be) begin
            edge_cnt_d = '0;
        end
        bit_cnt_d = bit_cnt_q;
        if (bit_clr) begin
            bit_cnt_d = '0;
        end else if (bit_inc) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detect, sampler timing, LSB-first deserialise,
// parity/stop checking and a one-cycle data_valid pulse for each good word.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned EDGE_W     = 5
) (
    input  logic                 clk,
    input  logic                 ARSTn,
    input  logic                 RX_IN,
    input  logic [5:0]           prescale,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    uart_rx_frame_ctrl_if.master rx_if
);
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH);

    rx_state_e             state_q, state_d;
    logic [5:0]            prescale_l_q, prescale_l_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic                  be;
    logic                  bit_clr;
    logic                  bit_inc;
    logic                  last_bit;
    logic                  sampled_bit;
    logic                  samp_en;
    logic [EDGE_W-1:0]     last_edge;
    logic [EDGE_W-1:0]     edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;

    assign sampled_bit = rx_if.sampled_bit;
    assign last_edge   = EDGE_W'(prescale_l_q - 6'd1);
    assign last_bit    = (bit_cnt == BIT_W'(DATA_WIDTH - 1));

    uart_rx_edge_bit_cnt #(
        .EDGE_W (EDGE_W),
        .BIT_W  (BIT_W)
    ) u_cnt (
        .clk       (clk),
        .ARSTn     (ARSTn),
        .en        (samp_en),
        .last_edge (last_edge),
        .bit_clr   (bit_clr),
        .bit_inc   (bit_inc),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .be        (be)
    );

    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!RX_IN) state_d = START;
            START:   if (be) state_d = sampled_bit ? IDLE : DATA;
            DATA:    if (be && last_bit) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (be) state_d = STOP;
            STOP:    if (be) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        samp_en      = (state_q != IDLE);
        prescale_l_d = prescale_l_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        shreg_d      = shreg_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;
        bit_clr      = 1'b0;
        bit_inc      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Frame config and error flags are only touched when a new start bit is seen.
                if (!RX_IN) begin
                    prescale_l_d = prescale;
                    par_en_d     = PAR_EN;
                    par_typ_d    = PAR_TYP;
                    par_err_d    = 1'b0;
                    stp_err_d    = 1'b0;
                end
            end
            START: begin
                if (be) bit_clr = 1'b1;
            end
            DATA: begin
                if (be) begin
                    shreg_d[bit_cnt] = sampled_bit;
                    bit_inc          = !last_bit;
                end
            end
            PARITY: begin
                if (be) par_err_d = sampled_bit != ((^shreg_q) ^ (par_typ_q == PAR_ODD));
            end
            STOP: begin
                if (be) begin
                    stp_err_d = ~sampled_bit;
                    if (sampled_bit && !par_err_q) begin
                        p_data_d     = shreg_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            prescale_l_q <= PRESCALE_8;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            shreg_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            prescale_l_q <= prescale_l_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            shreg_q      <= shreg_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign rx_if.data_samp_en = samp_en;
    assign rx_if.edge_cnt     = edge_cnt;
    assign rx_if.P_DATA       = p_data_q;
    assign rx_if.data_valid   = data_valid_q;
    assign rx_if.par_err      = par_err_q;
    assign rx_if.stp_err      = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl; the bench also plays the majority-vote sampler.
module tb_uart_rx_frame_ctrl;
    import uart_rx_pkg::*;

    typedef struct {
        logic [7:0]  data;
        int unsigned cyc;
    } sb_t;

    logic        clk;
    logic        ARSTn;
    logic        RX_IN;
    logic [5:0]  prescale;
    logic        PAR_EN;
    logic        PAR_TYP;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned s;
    bit          probe_on   = 1'b0;
    int unsigned probe_cyc  = 0;
    int unsigned probe_edge = 0;
    sb_t         sb[$];

    uart_rx_frame_ctrl_if #(.DATA_WIDTH(8), .EDGE_W(5)) rx_if ();

    uart_rx_frame_ctrl #(
        .DATA_WIDTH (8),
        .EDGE_W     (5)
    ) dut (
        .clk      (clk),
        .ARSTn    (ARSTn),
        .RX_IN    (RX_IN),
        .prescale (prescale),
        .PAR_EN   (PAR_EN),
        .PAR_TYP  (PAR_TYP),
        .rx_if    (rx_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] mk_frame(input logic [7:0] d, input logic pen,
                                             input logic ptyp, input logic pflip, input logic stop);
        logic [11:0] fr;
        fr      = '1;
        fr[0]   = 1'b0;
        fr[8:1] = d;
        if (pen) begin
            fr[9]  = (^d) ^ ptyp ^ pflip;
            fr[10] = stop;
        end else begin
            fr[9] = stop;
        end
        return fr;
    endfunction

    // Each bit lasts p clocks; the voted value appears mid-bit and is held until the next mid-bit.
    task automatic send_frame(input int unsigned p, input logic [11:0] fr, input int unsigned nb);
        for (int unsigned i = 0; i < nb; i++) begin
            RX_IN = fr[i];
            repeat (p / 2) @(negedge clk);
            rx_if.sampled_bit = fr[i];
            repeat (p - p / 2) @(negedge clk);
        end
    endtask

    task automatic idle(input int unsigned n);
        RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        rx_if.sampled_bit = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_word(input logic [7:0] d, input int unsigned at);
        sb_t e;
        e.data = d;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (probe_on && cyc == probe_cyc) begin
            check("edge_cnt_probe", 32'(rx_if.edge_cnt), probe_edge);
            check("samp_en_in_frame", 32'(rx_if.data_samp_en), 1);
        end
        if (rx_if.data_valid === 1'b1) begin
            check("pulse_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                sb_t e;
                e = sb.pop_front();
                check("P_DATA_on_pulse", 32'(rx_if.P_DATA), 32'(e.data));
                check("pulse_cycle", cyc, e.cyc);
                check("idle_after_stop", 32'(rx_if.data_samp_en), 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $error("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ARSTn = 1'b0;
        RX_IN = 1'b1;
        rx_if.sampled_bit = 1'b1;
        prescale = PRESCALE_8;
        PAR_EN = 1'b0;
        PAR_TYP = PAR_EVEN;
        repeat (3) @(negedge clk);
        check("rst_P_DATA", 32'(rx_if.P_DATA), 0);
        check("rst_data_valid", 32'(rx_if.data_valid), 0);
        check("rst_par_err", 32'(rx_if.par_err), 0);
        check("rst_stp_err", 32'(rx_if.stp_err), 0);
        check("rst_samp_en", 32'(rx_if.data_samp_en), 0);
        check("rst_edge_cnt", 32'(rx_if.edge_cnt), 0);
        ARSTn = 1'b1;
        idle(4);

        // 1: prescale 8, no parity, 0x55
        s = cyc;
        expect_word(8'h55, s + 81);
        probe_cyc  = s + 11;
        probe_edge = 2;
        probe_on   = 1'b1;
        send_frame(8, mk_frame(8'h55, 0, 0, 0, 1), 10);
        idle(4);
        probe_on = 1'b0;
        check("t1_par_err", 32'(rx_if.par_err), 0);
        check("t1_stp_err", 32'(rx_if.stp_err), 0);

        // 2: prescale 16, even parity, good then bad parity bit
        prescale = PRESCALE_16;
        PAR_EN   = 1'b1;
        PAR_TYP  = PAR_EVEN;
        s = cyc;
        expect_word(8'hA3, s + 11 * 16 + 1);
        send_frame(16, mk_frame(8'hA3, 1, 0, 0, 1), 11);
        idle(4);
        check("t2_good_par_err", 32'(rx_if.par_err), 0);
        send_frame(16, mk_frame(8'hA3 ^ 8'h00, 1, 0, 1, 1), 11);
        idle(4);
        check("t2_bad_par_err", 32'(rx_if.par_err), 1);
        check("t2_bad_stp_err", 32'(rx_if.stp_err), 0);
        check("t2_P_DATA_kept", 32'(rx_if.P_DATA), 32'h0A3);

        // 3: prescale 32, odd parity, stop error then recovery
        prescale = PRESCALE_32;
        PAR_TYP  = PAR_ODD;
        send_frame(32, mk_frame(8'h0F, 1, 1, 0, 0), 11);
        idle(4);
        check("t3_stp_err", 32'(rx_if.stp_err), 1);
        check("t3_par_err", 32'(rx_if.par_err), 0);
        check("t3_P_DATA_kept", 32'(rx_if.P_DATA), 32'h0A3);
        s = cyc;
        expect_word(8'h3C, s + 11 * 32 + 1);
        send_frame(32, mk_frame(8'h3C, 1, 1, 0, 1), 11);
        idle(4);
        check("t3_stp_err_clr", 32'(rx_if.stp_err), 0);

        // 4: two-clock start glitch at prescale 16
        prescale = PRESCALE_16;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        @(negedge clk);
        check("t4_samp_en_start", 32'(rx_if.data_samp_en), 1);
        @(negedge clk);
        RX_IN = 1'b1;
        repeat (20) @(negedge clk);
        check("t4_samp_en_idle", 32'(rx_if.data_samp_en), 0);
        check("t4_par_err", 32'(rx_if.par_err), 0);
        check("t4_stp_err", 32'(rx_if.stp_err), 0);
        check("t4_P_DATA_kept", 32'(rx_if.P_DATA), 32'h03C);

        // 5: back-to-back frames, the second start is seen one clock late
        s = cyc;
        expect_word(8'h81, s + 161);
        expect_word(8'h7E, s + 322);
        send_frame(16, mk_frame(8'h81, 0, 0, 0, 1), 10);
        send_frame(16, mk_frame(8'h7E, 0, 0, 0, 1), 10);
        idle(8);

        // config changes mid-frame must not affect the current frame
        prescale = PRESCALE_8;
        s = cyc;
        expect_word(8'h5A, s + 81);
        fork
            send_frame(8, mk_frame(8'h5A, 0, 0, 0, 1), 10);
            begin
                repeat (20) @(negedge clk);
                prescale = PRESCALE_32;
                PAR_EN   = 1'b1;
            end
        join
        prescale = PRESCALE_8;
        PAR_EN   = 1'b0;
        idle(4);
        check("t5_par_err", 32'(rx_if.par_err), 0);
        check("t5_stp_err", 32'(rx_if.stp_err), 0);

        // 6: reset in the middle of the data bits
        prescale = PRESCALE_16;
        send_frame(16, mk_frame(8'hFF, 0, 0, 0, 1), 4);
        check("t6_samp_en_mid", 32'(rx_if.data_samp_en), 1);
        ARSTn = 1'b0;
        RX_IN = 1'b1;
        @(negedge clk);
        check("t6_P_DATA", 32'(rx_if.P_DATA), 0);
        check("t6_data_valid", 32'(rx_if.data_valid), 0);
        check("t6_samp_en", 32'(rx_if.data_samp_en), 0);
        check("t6_edge_cnt", 32'(rx_if.edge_cnt), 0);
        check("t6_errs", 32'({rx_if.par_err, rx_if.stp_err}), 0);
        ARSTn = 1'b1;
        idle(4);
        s = cyc;
        expect_word(8'h12, s + 161);
        send_frame(16, mk_frame(8'h12, 0, 0, 0, 1), 10);
        idle(8);
        check("t6_P_DATA_new", 32'(rx_if.P_DATA), 32'h012);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
